tick_sched: RTL

- Programmable clock-enable scheduler for the 50 MHz domain.
- Replaces free-running divide counters with NCH runtime-configurable channels. Each channel emits a one-cycle tick strobe and a divided square wave.
- Consumers (sensor polling, UART baud, display refresh, 1 Hz housekeeping) share one configuration port. The port sequences divisor updates, channel enable/disable and phase resync without glitches.

---
 rtl/tick_sched_if.sv | 20 ++
 rtl/tick_sched.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tick_sched_if.sv
// Configuration request/response channel shared by all tick_sched consumers.
interface tick_sched_if #(parameter int DW = 32);
    logic          cfg_valid;
    logic          cfg_ready;
    logic [1:0]    cfg_op;
    logic [1:0]    cfg_ch;
    logic [DW-1:0] cfg_data;
    logic          cfg_done;
    logic          cfg_err;

    modport master (
        output cfg_valid, cfg_op, cfg_ch, cfg_data,
        input  cfg_ready, cfg_done, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_op, cfg_ch, cfg_data,
        output cfg_ready, cfg_done, cfg_err
    );
endinterface

// File: rtl/tick_sched.sv
// Programmable clock-enable scheduler: NCH wrap counters, each giving a tick strobe and a square wave.
// Config requests take handshake -> APPLY -> DONE (3 cycles); cfg_ready stays low outside IDLE.
module tick_sched #(
    parameter int             NCH    = 3,
    parameter int             DW     = 32,
    parameter logic [DW-1:0]  DEF0   = 50000,
    parameter logic [DW-1:0]  DEF1   = 2,
    parameter logic [DW-1:0]  DEF2   = 25,
    parameter logic [NCH-1:0] EN_RST = '1
) (
    input  logic           clk50M,
    input  logic           rst_n,
    tick_sched_if.slave    cfg,
    output logic [NCH-1:0] tick,
    output logic [NCH-1:0] sq,
    output logic [NCH-1:0] ch_en
);

    localparam logic [1:0] OP_SET  = 2'b00;
    localparam logic [1:0] OP_EN   = 2'b01;
    localparam logic [1:0] OP_DIS  = 2'b10;
    localparam logic [1:0] OP_SYNC = 2'b11;
    localparam logic [2:0] NCH3    = 3'(NCH);

    typedef enum logic [1:0] {
        S_INIT  = 2'd0,
        S_IDLE  = 2'd1,
        S_APPLY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic [1:0]    ch_q;
    logic [DW-1:0] data_q;
    logic          hs;
    logic          run;
    logic          apply;
    logic          ch_bad;
    logic          do_sync;

    assign hs      = cfg.cfg_valid && cfg.cfg_ready;
    assign run     = (state_q != S_INIT);
    assign apply   = (state_q == S_APPLY);
    // Resync targets every channel, so its cfg_ch field is never out of range.
    assign ch_bad  = (op_q != OP_SYNC) && ({1'b0, ch_q} >= NCH3);
    assign do_sync = apply && (op_q == OP_SYNC);

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
            op_q    <= OP_SET;
            ch_q    <= 2'b00;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (hs) begin
                op_q   <= cfg.cfg_op;
                ch_q   <= cfg.cfg_ch;
                data_q <= cfg.cfg_data;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cfg.cfg_ready = 1'b0;
        cfg.cfg_done  = 1'b0;
        cfg.cfg_err   = 1'b0;
        case (state_q)
            S_INIT:  state_d = S_IDLE;
            S_IDLE: begin
                cfg.cfg_ready = 1'b1;
                if (cfg.cfg_valid) state_d = S_APPLY;
            end
            S_APPLY: state_d = S_DONE;
            S_DONE: begin
                cfg.cfg_done = 1'b1;
                cfg.cfg_err  = ch_bad;
                state_d      = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        localparam logic [DW-1:0] DEFK = (k == 0) ? DEF0 :
                                         (k == 1) ? DEF1 :
                                         (k == 2) ? DEF2 : '0;

        logic [DW-1:0] cnt_q;
        logic [DW-1:0] act_q;
        logic [DW-1:0] shd_q;
        logic          en_q;
        logic          sq_q;
        logic          sel;
        logic          do_set;
        logic          do_en;
        logic          do_dis;
        logic          wrap;

        // Out-of-range cfg_ch never matches any channel index, so invalid requests touch nothing.
        assign sel    = apply && (ch_q == 2'(k));
        assign do_set = sel && (op_q == OP_SET);
        assign do_en  = sel && (op_q == OP_EN);
        assign do_dis = sel && (op_q == OP_DIS);
        assign wrap   = run && en_q && (cnt_q == act_q);

        assign tick[k]  = wrap && !do_dis;
        assign sq[k]    = sq_q;
        assign ch_en[k] = en_q;

        always_ff @(posedge clk50M or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q <= '0;
                act_q <= DEFK;
                shd_q <= DEFK;
                en_q  <= EN_RST[k];
                sq_q  <= 1'b0;
            end else if (run) begin
                if (do_set) shd_q <= data_q;
                if (do_dis) begin
                    en_q  <= 1'b0;
                    cnt_q <= '0;
                    sq_q  <= 1'b0;
                end else if (do_en) begin
                    en_q  <= 1'b1;
                    cnt_q <= '0;
                    sq_q  <= 1'b0;
                    act_q <= shd_q;
                end else if (!en_q) begin
                    cnt_q <= '0;
                    sq_q  <= 1'b0;
                    if (do_set) act_q <= data_q;
                end else if (do_sync) begin
                    cnt_q <= '0;
                    sq_q  <= 1'b0;
                    if (wrap) act_q <= shd_q;
                end else if (wrap) begin
                    // Old shadow is loaded here even if a set lands this cycle: the new value waits one period.
                    cnt_q <= '0;
                    sq_q  <= ~sq_q;
                    act_q <= shd_q;
                end else begin
                    cnt_q <= cnt_q + DW'(1);
                end
            end
        end
    end

endmodule
